// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing HI/LO for the multicycle CPU.
// Radix-2 Booth multiply and restoring magnitude divide, one step per clock.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_or_m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int              CntW     = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} stateT;

  stateT state;
  stateT stateNext;

  logic [CntW-1:0]  count;
  logic [WIDTH:0]   accP;     // Booth partial product with guard bit, or remainder
  logic [WIDTH-1:0] accQ;     // Booth multiplier, or dividend shifting into quotient
  logic             qMinus1;
  logic [WIDTH-1:0] opB;      // multiplicand for Booth, |divisor| for divide
  logic             isDiv;
  logic             divZero;
  logic             negQuo;
  logic             negRem;

  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic             bIsZero;
  logic [WIDTH:0]   boothSum;
  logic [WIDTH:0]   trial;
  logic             trialFits;
  logic [WIDTH-1:0] quoFixed;
  logic [WIDTH-1:0] remFixed;

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign aMag    = a[WIDTH-1] ? -a : a;
  assign bMag    = b[WIDTH-1] ? -b : b;
  assign bIsZero = (b == '0);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    boothSum = accP;
    case ({accQ[0], qMinus1})
      2'b01:   boothSum = accP + {opB[WIDTH-1], opB};
      2'b10:   boothSum = accP - {opB[WIDTH-1], opB};
      default: boothSum = accP;
    endcase
  end

  assign trial     = {accP[WIDTH-1:0], accQ[WIDTH-1]};
  assign trialFits = (trial >= {1'b0, opB});

  assign quoFixed = negQuo ? -accQ : accQ;
  assign remFixed = negRem ? -accP[WIDTH-1:0] : accP[WIDTH-1:0];

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          // Divide by zero skips iteration but still takes one FIX cycle so
          // done lands one edge after the request.
          if (div_or_m && bIsZero) stateNext = FIX;
          else if (div_or_m)       stateNext = DIV;
          else                     stateNext = MULT;
        end
      end
      MULT, DIV: begin
        if (count == LastStep) stateNext = FIX;
      end
      FIX:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: working registers carry no reset; they are always loaded at start
  // before being used, and the outputs depend only on state and hi/lo.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          isDiv   <= div_or_m;
          divZero <= div_or_m && bIsZero;
          negQuo  <= a[WIDTH-1] ^ b[WIDTH-1];
          negRem  <= a[WIDTH-1];
          accP    <= '0;
          qMinus1 <= 1'b0;
          accQ    <= div_or_m ? aMag : a;
          opB     <= div_or_m ? bMag : b;
        end
      end
      MULT: begin
        accP    <= {boothSum[WIDTH], boothSum[WIDTH:1]};
        accQ    <= {boothSum[0], accQ[WIDTH-1:1]};
        qMinus1 <= accQ[0];
      end
      DIV: begin
        accP <= trialFits ? (trial - {1'b0, opB}) : trial;
        accQ <= {accQ[WIDTH-2:0], trialFits};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (state == MULT || state == DIV) count <= count + CntW'(1);
      else                               count <= '0;

      if (state == FIX && !divZero) begin
        if (isDiv) begin
          hi <= remFixed;
          lo <= quoFixed;
        end else begin
          hi <= accP[WIDTH-1:0];
          lo <= accQ;
        end
      end
    end
  end

  assign busy     = (state == MULT) || (state == DIV) || (state == FIX);
  assign done     = (state == DONE);
  assign div_zero = (state == DONE) && divZero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of mult/div results and
// latencies, then reset-abort and start-while-busy sequences.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        div_or_m;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int nCompared;
  int nFailed;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .div_or_m (div_or_m),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          isDiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    bit          expDz;
    int          expLat;
  } vecT;

  vecT vec[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives a request for edge 0 and returns at the falling edge after it,
  // with operands scrambled to show they are not re-sampled.
  task automatic startOp(input bit isDiv, input logic [31:0] opA, input logic [31:0] opB);
    @(negedge clk);
    start    = 1'b1;
    div_or_m = isDiv;
    a        = opA;
    b        = opB;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    div_or_m = ~isDiv;
    a        = $urandom;
    b        = $urandom;
  endtask

  // Returns the number of edges after the start edge until done is seen,
  // or -1 if it never arrives within the budget.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int n = 0; n <= 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int doneCount;

    nCompared = 0;
    nFailed   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    div_or_m  = 1'b0;
    a         = '0;
    b         = '0;

    vec[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    vec[1]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33};
    vec[2]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
    vec[3]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vec[4]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
    vec[5]  = '{1'b1, 32'h0000_0005, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002, 1'b0, 33};
    vec[6]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 1'b1, 1};
    vec[7]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    vec[8]  = '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 33};
    vec[9]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
    vec[10] = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 33};
    vec[11] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 33};
    vec[12] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 33};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset hi", 64'(hi), 64'h0);
    check("reset lo", 64'(lo), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);
    check("reset div_zero", 64'(div_zero), 64'h0);

    for (int i = 0; i < 13; i++) begin
      startOp(vec[i].isDiv, vec[i].a, vec[i].b);
      check($sformatf("vec%0d busy after start", i), 64'(busy), 64'h1);
      waitDone(lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vec[i].expLat));
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vec[i].expHi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vec[i].expLo));
      check($sformatf("vec%0d div_zero", i), 64'(div_zero), 64'(vec[i].expDz));
      check($sformatf("vec%0d busy at done", i), 64'(busy), 64'h0);
      @(negedge clk);
      check($sformatf("vec%0d done drops", i), 64'(done), 64'h0);
      check($sformatf("vec%0d div_zero drops", i), 64'(div_zero), 64'h0);
    end

    // Busy profile of one mult: high through FIX, low in DONE.
    startOp(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    repeat (32) @(negedge clk);
    check("profile busy at edge 32", 64'(busy), 64'h1);
    check("profile done at edge 32", 64'(done), 64'h0);
    @(negedge clk);
    check("profile done at edge 33", 64'(done), 64'h1);
    check("profile busy at edge 33", 64'(busy), 64'h0);
    @(negedge clk);

    // Reset at edge 10 of a mult aborts it with nothing written to hi/lo.
    startOp(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort hi", 64'(hi), 64'h0);
    check("abort lo", 64'(lo), 64'h0);
    check("abort busy", 64'(busy), 64'h0);
    check("abort done", 64'(done), 64'h0);
    rst = 1'b0;
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    check("abort no late done", 64'(doneCount), 64'h0);
    check("abort hi stays", 64'(hi), 64'h0);

    startOp(1'b0, 32'h0000_0003, 32'h0000_0004);
    waitDone(lat);
    check("post-reset latency", 64'(lat), 64'd33);
    check("post-reset hi", 64'(hi), 64'h0);
    check("post-reset lo", 64'(lo), 64'd12);
    @(negedge clk);

    // Starts while busy and while in DONE are ignored.
    startOp(1'b0, 32'h0000_0005, 32'h0000_0006);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    div_or_m = 1'b1;
    a        = 32'h0000_0064;
    b        = 32'h0000_0007;
    @(negedge clk);
    start     = 1'b0;
    doneCount = 0;
    for (int n = 0; n < 80; n++) begin
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin
          check("busy-start hi", 64'(hi), 64'h0);
          check("busy-start lo", 64'(lo), 64'd30);
        end
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy-start single done", 64'(doneCount), 64'd1);
    check("busy-start result kept", 64'(lo), 64'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
